// File: rtl/trail_plotter_if.sv
// trail_plotter_if -- step, clear and plot signals between the round logic,
// the trail plotter and the vga_adapter.
//
//   tick        step pulse from the movement timer (heads valid same cycle)
//   p1_x/p1_y   player 1 head (8/7 bits)
//   p2_x/p2_y   player 2 head (8/7 bits)
//   clear_req   one-cycle request to wipe screen and bitmap
//   vga_x/vga_y/vga_colour/vga_plot   pixel write to the vga_adapter
//   busy        plotter is working on a step or a clear sweep
//   step_done   one-cycle pulse, step result valid
//   hit_p1/hit_p2   crash flags, held until the next accepted step or a clear
//   clear_done  one-cycle pulse at the end of a clear sweep
//
// master: the round/timer side driving steps; slave: the plotter itself.
`timescale 1ns/1ps
interface trail_plotter_if;
    logic       tick;
    logic [7:0] p1_x;
    logic [6:0] p1_y;
    logic [7:0] p2_x;
    logic [6:0] p2_y;
    logic       clear_req;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;
    logic       step_done;
    logic       hit_p1;
    logic       hit_p2;
    logic       clear_done;

    modport master (
        output tick, p1_x, p1_y, p2_x, p2_y, clear_req,
        input  vga_x, vga_y, vga_colour, vga_plot,
        input  busy, step_done, hit_p1, hit_p2, clear_done
    );

    modport slave (
        input  tick, p1_x, p1_y, p2_x, p2_y, clear_req,
        output vga_x, vga_y, vga_colour, vga_plot,
        output busy, step_done, hit_p1, hit_p2, clear_done
    );
endinterface

// File: rtl/trail_plotter.sv
// trail_plotter -- keeps a one-bit occupancy bitmap of every trail pixel,
// checks both player heads on each step against the border, the trail and
// each other, plots surviving heads and sweeps the screen between rounds.
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      trail_plotter_if.slave (step inputs, vga plot outputs, status)
//
// A step takes tick -> RD1 -> CHK1 -> RD2 -> CHK2 -> REPORT; p1 is plotted in
// CHK1 (T+2), p2 in CHK2 (T+4), step_done / hit_* are valid in REPORT (T+5).
`timescale 1ns/1ps
module trail_plotter #(
    parameter logic [2:0] P1_COLOUR    = 3'b101,
    parameter logic [2:0] P2_COLOUR    = 3'b010,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000,
    parameter int         SCR_W        = 160,
    parameter int         SCR_H        = 120
) (
    input  logic            clk,
    input  logic            reset_n,
    trail_plotter_if.slave  bus
);

    localparam int          DEPTH   = SCR_W * SCR_H;
    localparam logic [14:0] DEPTH_L = 15'(DEPTH);
    localparam logic [7:0]  X_LIM   = 8'(SCR_W);
    localparam logic [6:0]  Y_LIM   = 7'(SCR_H);
    localparam logic [7:0]  X_LAST  = 8'(SCR_W - 1);
    localparam logic [6:0]  Y_LAST  = 7'(SCR_H - 1);

    typedef enum logic [2:0] {
        IDLE, RD1, CHK1, RD2, CHK2, REPORT, OVER, CLEAR
    } state_t;

    // y*160 + x without a multiplier
    function automatic logic [14:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
        return {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};
    endfunction

    state_t      state_reg, state_next;
    logic        alive_reg;
    logic [7:0]  cx_reg;
    logic [6:0]  cy_reg;
    logic [7:0]  p1x_reg, p2x_reg;
    logic [6:0]  p1y_reg, p2y_reg;
    logic        h1_reg;
    logic        hit1_reg, hit2_reg;
    logic [7:0]  vga_x_reg;
    logic [6:0]  vga_y_reg;
    logic [2:0]  vga_colour_reg;

    // bitmap RAM
    logic        bitmap [0:DEPTH-1];
    logic        rd_data_reg;
    logic        ram_we;
    logic [14:0] ram_waddr;
    logic        ram_wdata;
    logic [14:0] ram_raddr;

    // combinational step/plot signals
    logic        border1, border2, same_pos, last_pix;
    logic        h1_chk, h2_chk;
    logic [14:0] addr1, addr2, addr_clr;
    logic        plot_next;
    logic [7:0]  px_next;
    logic [6:0]  py_next;
    logic [2:0]  pc_next;
    logic        busy_next, step_done_next, clear_done_next;

    assign addr1    = pix_addr(p1x_reg, p1y_reg);
    assign addr2    = pix_addr(p2x_reg, p2y_reg);
    assign addr_clr = pix_addr(cx_reg, cy_reg);
    assign border1  = (p1x_reg >= X_LIM) || (p1y_reg >= Y_LIM);
    assign border2  = (p2x_reg >= X_LIM) || (p2y_reg >= Y_LIM);
    assign same_pos = (p1x_reg == p2x_reg) && (p1y_reg == p2y_reg);
    assign last_pix = (cx_reg == X_LAST) && (cy_reg == Y_LAST);
    assign h1_chk   = border1 | rd_data_reg;
    // rd_data_reg already reflects p1's bit written in CHK1
    assign h2_chk   = border2 | rd_data_reg | same_pos;

    // Synchronous-read RAM. Out-of-range read addresses only occur for heads
    // that are already border hits, so they simply read as empty.
    always_ff @(posedge clk) begin
        if (ram_we)
            bitmap[ram_waddr] <= ram_wdata;
        if (ram_raddr < DEPTH_L)
            rd_data_reg <= bitmap[ram_raddr];
        else
            rd_data_reg <= 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_reg <= CLEAR;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next      = state_reg;
        ram_we          = 1'b0;
        ram_waddr       = addr_clr;
        ram_wdata       = 1'b0;
        ram_raddr       = addr2;
        plot_next       = 1'b0;
        px_next         = vga_x_reg;
        py_next         = vga_y_reg;
        pc_next         = vga_colour_reg;
        busy_next       = 1'b0;
        step_done_next  = 1'b0;
        clear_done_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.clear_req)
                    state_next = CLEAR;
                else if (bus.tick)
                    state_next = RD1;
            end
            RD1: begin
                busy_next  = 1'b1;
                ram_raddr  = addr1;
                state_next = CHK1;
            end
            CHK1: begin
                busy_next = 1'b1;
                if (!h1_chk) begin
                    ram_we    = 1'b1;
                    ram_waddr = addr1;
                    ram_wdata = 1'b1;
                    plot_next = 1'b1;
                    px_next   = p1x_reg;
                    py_next   = p1y_reg;
                    pc_next   = P1_COLOUR;
                end
                state_next = RD2;
            end
            RD2: begin
                busy_next  = 1'b1;
                ram_raddr  = addr2;
                state_next = CHK2;
            end
            CHK2: begin
                busy_next = 1'b1;
                if (!h2_chk) begin
                    ram_we    = 1'b1;
                    ram_waddr = addr2;
                    ram_wdata = 1'b1;
                    plot_next = 1'b1;
                    px_next   = p2x_reg;
                    py_next   = p2y_reg;
                    pc_next   = P2_COLOUR;
                end
                state_next = REPORT;
            end
            REPORT: begin
                busy_next      = 1'b1;
                step_done_next = 1'b1;
                state_next     = (hit1_reg || hit2_reg) ? OVER : IDLE;
            end
            OVER: begin
                if (bus.clear_req)
                    state_next = CLEAR;
            end
            CLEAR: begin
                // The first cycle out of reset is held off so that every
                // output reads 0 until the clock has actually run once.
                if (alive_reg) begin
                    busy_next = 1'b1;
                    ram_we    = 1'b1;
                    ram_waddr = addr_clr;
                    ram_wdata = 1'b0;
                    plot_next = 1'b1;
                    px_next   = cx_reg;
                    py_next   = cy_reg;
                    pc_next   = CLEAR_COLOUR;
                    if (last_pix) begin
                        clear_done_next = 1'b1;
                        state_next      = IDLE;
                    end
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alive_reg      <= 1'b0;
            cx_reg         <= '0;
            cy_reg         <= '0;
            p1x_reg        <= '0;
            p1y_reg        <= '0;
            p2x_reg        <= '0;
            p2y_reg        <= '0;
            h1_reg         <= 1'b0;
            hit1_reg       <= 1'b0;
            hit2_reg       <= 1'b0;
            vga_x_reg      <= '0;
            vga_y_reg      <= '0;
            vga_colour_reg <= '0;
        end else begin
            alive_reg <= 1'b1;
            if (state_reg == IDLE && !bus.clear_req && bus.tick) begin
                p1x_reg  <= bus.p1_x;
                p1y_reg  <= bus.p1_y;
                p2x_reg  <= bus.p2_x;
                p2y_reg  <= bus.p2_y;
                hit1_reg <= 1'b0;
                hit2_reg <= 1'b0;
            end
            if (state_reg == CHK1)
                h1_reg <= h1_chk;
            // loaded on leaving CHK2 so the flags are already valid in REPORT
            if (state_reg == CHK2) begin
                hit1_reg <= h1_reg | same_pos;
                hit2_reg <= h2_chk;
            end
            if (state_reg == CLEAR && alive_reg) begin
                if (last_pix) begin
                    cx_reg   <= '0;
                    cy_reg   <= '0;
                    hit1_reg <= 1'b0;
                    hit2_reg <= 1'b0;
                end else if (cx_reg == X_LAST) begin
                    cx_reg <= '0;
                    cy_reg <= cy_reg + 7'd1;
                end else begin
                    cx_reg <= cx_reg + 8'd1;
                end
            end
            if (plot_next) begin
                vga_x_reg      <= px_next;
                vga_y_reg      <= py_next;
                vga_colour_reg <= pc_next;
            end
        end
    end

    assign bus.vga_x      = px_next;
    assign bus.vga_y      = py_next;
    assign bus.vga_colour = pc_next;
    assign bus.vga_plot   = plot_next;
    assign bus.busy       = busy_next;
    assign bus.step_done  = step_done_next;
    assign bus.clear_done = clear_done_next;
    assign bus.hit_p1     = hit1_reg;
    assign bus.hit_p2     = hit2_reg;

endmodule

// File: tb/tb_trail_plotter.sv
`timescale 1ns/1ps
module tb_trail_plotter;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    trail_plotter_if bus ();

    trail_plotter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // sweep statistics
    int sw_busy, sw_plots, sw_badcol, sw_done, sw_done_at, sw_busy0;
    int sw_fx, sw_fy, sw_lx, sw_ly;
    // step recording, index k = cycles after the tick cycle
    int rec_pl [1:7];
    int rec_x  [1:7];
    int rec_y  [1:7];
    int rec_c  [1:7];
    int rec_sd [1:7];
    int rec_h1 [1:7];
    int rec_h2 [1:7];
    int rec_bz [1:7];
    int rec_np, rec_nsd;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Samples one full clear sweep; optionally pulses clear_req mid-sweep.
    task automatic sweep(input bit req_mid);
        bit got_first;
        got_first = 1'b0;
        sw_busy = 0; sw_plots = 0; sw_badcol = 0; sw_done = 0; sw_done_at = -1;
        sw_busy0 = 0; sw_fx = -1; sw_fy = -1; sw_lx = -1; sw_ly = -1;
        for (int i = 0; i < 19210; i++) begin
            @(negedge clk);
            if (i == 0) sw_busy0 = int'(bus.busy);
            if (bus.busy) sw_busy++;
            if (bus.vga_plot) begin
                if (!got_first) begin
                    sw_fx = int'(bus.vga_x);
                    sw_fy = int'(bus.vga_y);
                    got_first = 1'b1;
                end
                sw_lx = int'(bus.vga_x);
                sw_ly = int'(bus.vga_y);
                sw_plots++;
                if (bus.vga_colour != 3'b000) sw_badcol++;
            end
            if (bus.clear_done) begin
                sw_done++;
                sw_done_at = i;
            end
            bus.tick      = 1'b0;
            bus.clear_req = req_mid && (i == 100);
        end
        bus.clear_req = 1'b0;
    endtask

    task automatic step(input logic [7:0] ax, input logic [6:0] ay,
                        input logic [7:0] bx, input logic [6:0] by);
        @(negedge clk);
        bus.tick = 1'b1;
        bus.p1_x = ax; bus.p1_y = ay;
        bus.p2_x = bx; bus.p2_y = by;
        rec_np = 0; rec_nsd = 0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            rec_pl[k] = int'(bus.vga_plot);
            rec_x[k]  = int'(bus.vga_x);
            rec_y[k]  = int'(bus.vga_y);
            rec_c[k]  = int'(bus.vga_colour);
            rec_sd[k] = int'(bus.step_done);
            rec_h1[k] = int'(bus.hit_p1);
            rec_h2[k] = int'(bus.hit_p2);
            rec_bz[k] = int'(bus.busy);
            rec_np  += rec_pl[k];
            rec_nsd += rec_sd[k];
            bus.tick = 1'b0;
        end
    endtask

    task automatic check_sweep(input string tag);
        chk({tag, "_busy_first"}, sw_busy0, 1);
        chk({tag, "_busy_cycles"}, sw_busy, 19200);
        chk({tag, "_strobes"}, sw_plots, 19200);
        chk({tag, "_bad_colour"}, sw_badcol, 0);
        chk({tag, "_done_pulses"}, sw_done, 1);
        chk({tag, "_done_at"}, sw_done_at, 19199);
        chk({tag, "_first_x"}, sw_fx, 0);
        chk({tag, "_first_y"}, sw_fy, 0);
        chk({tag, "_last_x"}, sw_lx, 159);
        chk({tag, "_last_y"}, sw_ly, 119);
        chk({tag, "_hit_p1"}, int'(bus.hit_p1), 0);
        chk({tag, "_hit_p2"}, int'(bus.hit_p2), 0);
    endtask

    initial begin
        bus.tick = 1'b0; bus.clear_req = 1'b0;
        bus.p1_x = '0; bus.p1_y = '0; bus.p2_x = '0; bus.p2_y = '0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_plot", int'(bus.vga_plot), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_step_done", int'(bus.step_done), 0);
        chk("rst_clear_done", int'(bus.clear_done), 0);
        chk("rst_hit_p1", int'(bus.hit_p1), 0);
        chk("rst_x", int'(bus.vga_x), 0);
        reset_n = 1'b1;
        sweep(1'b0);
        check_sweep("boot");
        $display("boot sweep: busy=%0d strobes=%0d done_at=%0d", sw_busy, sw_plots, sw_done_at);

        // clean step
        step(8'd10, 7'd10, 8'd150, 7'd110);
        $display("step A: plots=%0d step_done=%0d hits=%0d/%0d", rec_np, rec_nsd, rec_h1[5], rec_h2[5]);
        chk("A_plot_T1", rec_pl[1], 0);
        chk("A_plot_T2", rec_pl[2], 1);
        chk("A_x_T2", rec_x[2], 10);
        chk("A_y_T2", rec_y[2], 10);
        chk("A_col_T2", rec_c[2], 5);
        chk("A_x_hold_T3", rec_x[3], 10);
        chk("A_col_hold_T3", rec_c[3], 5);
        chk("A_plot_T4", rec_pl[4], 1);
        chk("A_x_T4", rec_x[4], 150);
        chk("A_y_T4", rec_y[4], 110);
        chk("A_col_T4", rec_c[4], 2);
        chk("A_nplots", rec_np, 2);
        chk("A_done_T5", rec_sd[5], 1);
        chk("A_ndone", rec_nsd, 1);
        chk("A_hit_p1", rec_h1[5], 0);
        chk("A_hit_p2", rec_h2[5], 0);
        chk("A_busy_T4", rec_bz[4], 1);
        chk("A_busy_T6", rec_bz[6], 0);

        // p1 runs into its own trail
        step(8'd10, 7'd10, 8'd149, 7'd110);
        $display("step B: plots=%0d step_done=%0d hits=%0d/%0d", rec_np, rec_nsd, rec_h1[5], rec_h2[5]);
        chk("B_plot_T2", rec_pl[2], 0);
        chk("B_x_hold_T2", rec_x[2], 150);
        chk("B_plot_T4", rec_pl[4], 1);
        chk("B_x_T4", rec_x[4], 149);
        chk("B_col_T4", rec_c[4], 2);
        chk("B_nplots", rec_np, 1);
        chk("B_done_T5", rec_sd[5], 1);
        chk("B_hit_p1", rec_h1[5], 1);
        chk("B_hit_p2", rec_h2[5], 0);
        chk("B_hit_p1_held", rec_h1[7], 1);
        chk("B_busy_T6", rec_bz[6], 0);

        // tick in OVER is ignored
        step(8'd20, 7'd20, 8'd30, 7'd30);
        $display("step C (over): plots=%0d step_done=%0d hits=%0d/%0d", rec_np, rec_nsd, rec_h1[7], rec_h2[7]);
        chk("C_nplots", rec_np, 0);
        chk("C_ndone", rec_nsd, 0);
        chk("C_busy_T2", rec_bz[2], 0);
        chk("C_hit_p1_held", rec_h1[7], 1);
        chk("C_hit_p2_held", rec_h2[7], 0);

        // clear_req together with tick from OVER; clear_req mid-sweep ignored
        @(negedge clk);
        bus.clear_req = 1'b1;
        bus.tick = 1'b1;
        bus.p1_x = 8'd10; bus.p1_y = 7'd10; bus.p2_x = 8'd20; bus.p2_y = 7'd20;
        sweep(1'b1);
        check_sweep("clr1");
        $display("clear 1: busy=%0d strobes=%0d done_at=%0d", sw_busy, sw_plots, sw_done_at);

        // bitmap zeroed: (10,10) is free again
        step(8'd10, 7'd10, 8'd20, 7'd20);
        $display("step D: plots=%0d step_done=%0d hits=%0d/%0d", rec_np, rec_nsd, rec_h1[5], rec_h2[5]);
        chk("D_plot_T2", rec_pl[2], 1);
        chk("D_plot_T4", rec_pl[4], 1);
        chk("D_y_T4", rec_y[4], 20);
        chk("D_hit_p1", rec_h1[5], 0);
        chk("D_hit_p2", rec_h2[5], 0);

        // both heads off-screen
        step(8'd160, 7'd5, 8'd3, 7'd120);
        $display("step E: plots=%0d step_done=%0d hits=%0d/%0d", rec_np, rec_nsd, rec_h1[5], rec_h2[5]);
        chk("E_nplots", rec_np, 0);
        chk("E_done_T5", rec_sd[5], 1);
        chk("E_hit_p1", rec_h1[5], 1);
        chk("E_hit_p2", rec_h2[5], 1);

        // plain clear from OVER
        @(negedge clk);
        bus.clear_req = 1'b1;
        sweep(1'b0);
        check_sweep("clr2");
        $display("clear 2: busy=%0d strobes=%0d done_at=%0d", sw_busy, sw_plots, sw_done_at);

        // head-on collision on a clear screen
        step(8'd80, 7'd60, 8'd80, 7'd60);
        $display("step F: plots=%0d step_done=%0d hits=%0d/%0d", rec_np, rec_nsd, rec_h1[5], rec_h2[5]);
        chk("F_plot_T2", rec_pl[2], 1);
        chk("F_x_T2", rec_x[2], 80);
        chk("F_y_T2", rec_y[2], 60);
        chk("F_col_T2", rec_c[2], 5);
        chk("F_plot_T4", rec_pl[4], 0);
        chk("F_nplots", rec_np, 1);
        chk("F_hit_p1", rec_h1[5], 1);
        chk("F_hit_p2", rec_h2[5], 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/trail_plotter.md
Name: trail_plotter

Overview:
- Consumes per-step player head positions from the movement timer. Keeps a 160x120 one-bit occupancy bitmap of every trail pixel already drawn.
- On each step it checks both heads against the screen border, the existing trail and each other. It then plots the surviving heads into the single vga_adapter through x/y/colour/plot and reports collisions to the round/score logic.
- It also owns screen clearing between rounds.

Parameters:
- P1_COLOUR, 3'b101, colour plotted for player 1 head.
- P2_COLOUR, 3'b010, colour plotted for player 2 head.
- CLEAR_COLOUR, 3'b000, colour written during clear sweep.
- SCR_W, 160, screen width in pixels.
- SCR_H, 120, screen height in pixels.

Ports:
- clk  in  1  system clock (CLOCK_50 at top).
- reset_n  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle step pulse from the timer; heads valid in the same cycle.
- p1_x  in  8  player 1 head x.
- p1_y  in  7  player 1 head y.
- p2_x  in  8  player 2 head x.
- p2_y  in  7  player 2 head y.
- clear_req  in  1  one-cycle request to wipe screen and bitmap (new round).
- vga_x  out  8  plot x to vga_adapter.
- vga_y  out  7  plot y.
- vga_colour  out  3  plot colour.
- vga_plot  out  1  plot strobe, one pixel per high cycle.
- busy  out  1  high in every state except IDLE and OVER.
- step_done  out  1  one-cycle pulse when a step's result is valid.
- hit_p1  out  1  player 1 crashed; registered and held until the next accepted step or a clear.
- hit_p2  out  1  player 2 crashed; same hold rules as hit_p1.
- clear_done  out  1  one-cycle pulse at the end of a clear sweep.

Behaviour:
- Reset (async): all outputs 0. State goes to CLEAR with counters at 0, so busy=1 the cycle after reset releases. The bitmap is never reset directly; it is zeroed by the sweep.
- Bitmap: 19200x1 RAM with synchronous read (1-cycle latency) and one write port. Address = y*160+x, computed as (y<<7)+(y<<5)+x, 15 bits.
- States: IDLE, RD1, CHK1, RD2, CHK2, REPORT, OVER, CLEAR.
- IDLE:
  - clear_req -> CLEAR. clear_req wins if asserted together with tick.
  - Else tick -> latch all four coordinates, go to RD1.
- RD1: present the p1 address to the RAM. -> CHK1.
- CHK1:
  - h1 = (x>=SCR_W) | (y>=SCR_H) | occ.
  - If !h1: write bit 1 and plot p1 with P1_COLOUR.
  - -> RD2.
- RD2: present the p2 address to the RAM. -> CHK2.
- CHK2:
  - h2 = border | occ. Occ includes p1's bit written in CHK1.
  - Head-on: if p1 == p2, force h1 = h2 = 1. p1 was already plotted and stays plotted; this is accepted cosmetic behaviour.
  - If !h2: write and plot p2 with P2_COLOUR.
  - -> REPORT.
- REPORT:
  - hit_p1 <= h1, hit_p2 <= h2, step_done = 1.
  - -> OVER if h1|h2, else IDLE.
- Latency: tick at cycle T -> plots at T+2 (p1) and T+4 (p2); step_done and hit_* at T+5. Minimum tick spacing is 6 cycles.
- tick is ignored outside IDLE: no queuing, no error.
- OVER: ignores tick; hit_* held; clear_req -> CLEAR.
- CLEAR:
  - x counter 0..159 and y counter 0..119; x wraps to 0 and y increments when x = 159.
  - Each cycle: write bitmap 0 at (x,y) and plot CLEAR_COLOUR at (x,y).
  - After (159,119) is written: pulse clear_done, clear hit_*, go to IDLE.
  - Takes exactly 19200 cycles.
  - clear_req during CLEAR is ignored; the sweep is not restarted.
- Border check uses the full input widths: x in 160..255 or y in 120..127 is a hit. Out-of-range coordinates are never written or plotted.
- vga_plot is high only in CHK1/CHK2 (no-hit case) and CLEAR; vga_x/vga_y/vga_colour hold their last value otherwise.
- Reset asserted mid-step or mid-clear: immediate return to the reset state, followed by a full re-sweep.

Test Plan:
- Reset, wait -> busy for exactly 19200 cycles, 19200 vga_plot strobes with colour 000, clear_done pulse, first strobe (0,0), last strobe (159,119).
- Clear, then tick with p1=(10,10), p2=(150,110) -> plot (10,10)/101 at T+2, plot (150,110)/010 at T+4, step_done at T+5, hit_p1=hit_p2=0.
- Repeat a tick with p1=(10,10), p2=(149,110) -> hit_p1=1, hit_p2=0, p1 not plotted, state OVER, next tick ignored (no plot, no step_done).
- Tick with p1=(160,5), p2=(3,120) -> hit_p1=hit_p2=1, no vga_plot strobes during the step.
- Tick with p1=p2=(80,60) on a clear screen -> one plot at (80,60)/101, hit_p1=hit_p2=1.
- From OVER, pulse clear_req together with tick -> CLEAR entered, bitmap zeroed; a following tick at (10,10) -> no hit.
